// File: rtl/rpm_counter.sv
// Hall-sensor RPM measurement: synchronise, debounce, count rising edges per gate
// window, then convert count*60/PULSES_PER_REV with a shift-add multiply and restoring divide.
module rpm_counter #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned PULSES_PER_REV  = 1,
  parameter int unsigned CNT_W           = 16,
  localparam int unsigned RPM_W          = CNT_W + 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hall_in,
  input  logic             gate_tick,
  output logic [RPM_W-1:0] rpm,
  output logic             rpm_valid,
  output logic             rpm_sat,
  output logic             busy,
  output logic             missed_tick
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned DIV_CW = $clog2(RPM_W);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_CW-1:0] DIV_LAST = DIV_CW'(RPM_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [RPM_W:0]    DIVISOR  = (RPM_W + 1)'(PULSES_PER_REV);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic [DB_W-1:0]         db_cnt_q, db_cnt_d;
  logic                    hall_db_q, hall_db_d;
  logic                    hall_db_prev_q, hall_db_prev_d;
  logic [CNT_W-1:0]        edge_cnt_q, edge_cnt_d;
  logic                    win_sat_q, win_sat_d;
  logic [CNT_W-1:0]        snap_q, snap_d;
  logic                    snap_sat_q, snap_sat_d;
  logic [RPM_W-1:0]        quo_q, quo_d;
  logic [RPM_W-1:0]        rem_q, rem_d;
  logic [DIV_CW-1:0]       div_cnt_q, div_cnt_d;
  logic [RPM_W-1:0]        rpm_q, rpm_d;
  logic                    rpm_valid_q, rpm_valid_d;
  logic                    rpm_sat_q, rpm_sat_d;
  logic                    busy_q, busy_d;
  logic                    missed_q, missed_d;

  logic                    hall_s;
  logic                    rise_c;
  logic                    qbit_c;
  logic [RPM_W:0]          rem_shift_c;

  assign hall_s = sync_q[SYNC_STAGES-1];
  assign rise_c = hall_db_q & ~hall_db_prev_q;

  // State register and all datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      sync_q         <= '0;
      db_cnt_q       <= '0;
      hall_db_q      <= 1'b0;
      hall_db_prev_q <= 1'b0;
      edge_cnt_q     <= '0;
      win_sat_q      <= 1'b0;
      snap_q         <= '0;
      snap_sat_q     <= 1'b0;
      quo_q          <= '0;
      rem_q          <= '0;
      div_cnt_q      <= '0;
      rpm_q          <= '0;
      rpm_valid_q    <= 1'b0;
      rpm_sat_q      <= 1'b0;
      busy_q         <= 1'b0;
      missed_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      db_cnt_q       <= db_cnt_d;
      hall_db_q      <= hall_db_d;
      hall_db_prev_q <= hall_db_prev_d;
      edge_cnt_q     <= edge_cnt_d;
      win_sat_q      <= win_sat_d;
      snap_q         <= snap_d;
      snap_sat_q     <= snap_sat_d;
      quo_q          <= quo_d;
      rem_q          <= rem_d;
      div_cnt_q      <= div_cnt_d;
      rpm_q          <= rpm_d;
      rpm_valid_q    <= rpm_valid_d;
      rpm_sat_q      <= rpm_sat_d;
      busy_q         <= busy_d;
      missed_q       <= missed_d;
    end
  end

  // Next-state, window counting and conversion datapath
  always_comb begin
    state_d        = state_q;
    sync_d         = {sync_q[SYNC_STAGES-2:0], hall_in};
    db_cnt_d       = db_cnt_q;
    hall_db_d      = hall_db_q;
    hall_db_prev_d = hall_db_q;
    edge_cnt_d     = edge_cnt_q;
    win_sat_d      = win_sat_q;
    snap_d         = snap_q;
    snap_sat_d     = snap_sat_q;
    quo_d          = quo_q;
    rem_d          = rem_q;
    div_cnt_d      = div_cnt_q;
    rpm_d          = rpm_q;
    rpm_valid_d    = 1'b0;
    rpm_sat_d      = rpm_sat_q;
    missed_d       = missed_q;
    qbit_c         = 1'b0;
    rem_shift_c    = {rem_q, quo_q[RPM_W-1]};

    // Level only changes after DEBOUNCE_CYCLES consecutive differing samples
    if (hall_s == hall_db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      hall_db_d = hall_s;
      db_cnt_d  = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(1);
    end

    // An edge coinciding with the tick opens the new window
    if (gate_tick) begin
      edge_cnt_d = rise_c ? CNT_W'(1) : '0;
      win_sat_d  = 1'b0;
    end else if (rise_c) begin
      if (edge_cnt_q == CNT_MAX) win_sat_d = 1'b1;
      else                       edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end

    if (gate_tick && (state_q != S_IDLE)) missed_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (gate_tick) begin
          snap_d     = edge_cnt_q;
          snap_sat_d = win_sat_q;
          state_d    = S_MUL;
        end
      end
      S_MUL: begin
        quo_d     = (RPM_W'(snap_q) << 6) - (RPM_W'(snap_q) << 2);
        rem_d     = '0;
        div_cnt_d = '0;
        state_d   = S_DIV;
      end
      S_DIV: begin
        if (rem_shift_c >= DIVISOR) begin
          qbit_c = 1'b1;
          rem_d  = RPM_W'(rem_shift_c - DIVISOR);
        end else begin
          rem_d  = RPM_W'(rem_shift_c);
        end
        quo_d = {quo_q[RPM_W-2:0], qbit_c};
        if (div_cnt_q == DIV_LAST) begin
          rpm_d       = quo_d;
          rpm_sat_d   = snap_sat_q;
          rpm_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          div_cnt_d = div_cnt_q + DIV_CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign rpm         = rpm_q;
  assign rpm_valid   = rpm_valid_q;
  assign rpm_sat     = rpm_sat_q;
  assign busy        = busy_q;
  assign missed_tick = missed_q;

endmodule

// File: tb/tb_rpm_counter.sv
// Directed bench for rpm_counter: per-cycle comparison against a window/latency model
// plus hand-computed RPM results for each scenario.
module tb_rpm_counter;

  localparam int unsigned SS    = 2;
  localparam int unsigned DC    = 4;
  localparam int unsigned PPR   = 2;
  localparam int unsigned CW    = 8;
  localparam int unsigned RW    = CW + 6;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hall_in = 1'b0;
  logic          gate_tick = 1'b0;
  logic [RW-1:0] rpm;
  logic          rpm_valid, rpm_sat, busy, missed_tick;

  int n_checks = 0;
  int n_fail   = 0;

  rpm_counter #(
    .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .PULSES_PER_REV(PPR), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .hall_in(hall_in), .gate_tick(gate_tick),
    .rpm(rpm), .rpm_valid(rpm_valid), .rpm_sat(rpm_sat),
    .busy(busy), .missed_tick(missed_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: raw input run lengths decide accepted levels; each accepted rise is
  // credited SS+1 clocks after its DC-th stable sample. Results appear RW+1
  // clocks after an accepted tick.
  int cyc = 0;
  int run = 0;
  bit m_db = 0;
  bit edge_now = 0;
  int edge_q[$];
  int win = 0;
  int busy_until = -100;
  int due_q[$];
  int val_q[$];
  bit sat_q[$];
  int m_rpm = 0;
  bit m_sat = 0, m_valid = 0, m_missed = 0, m_busy = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      run = 0; m_db = 0; win = 0; busy_until = -100;
      edge_q.delete(); due_q.delete(); val_q.delete(); sat_q.delete();
      m_rpm = 0; m_sat = 0; m_valid = 0; m_missed = 0; m_busy = 0;
    end else begin
      if (hall_in != m_db) begin
        run++;
        if (run == DC) begin
          m_db = hall_in;
          run  = 0;
          if (m_db) edge_q.push_back(cyc + SS + 1);
        end
      end else begin
        run = 0;
      end
      edge_now = (edge_q.size() > 0) && (edge_q[0] == cyc);
      if (edge_now) void'(edge_q.pop_front());
      if (gate_tick) begin
        if (cyc >= busy_until + 2) begin
          due_q.push_back(cyc + RW + 1);
          val_q.push_back(((win > CMAX) ? CMAX : win) * 60 / PPR);
          sat_q.push_back(win > CMAX);
          busy_until = cyc + RW + 1;
        end else begin
          m_missed = 1;
        end
        win = edge_now ? 1 : 0;
      end else if (edge_now) begin
        win++;
      end
      m_valid = 0;
      if ((due_q.size() > 0) && (due_q[0] == cyc)) begin
        void'(due_q.pop_front());
        m_valid = 1;
        m_rpm   = val_q.pop_front();
        m_sat   = sat_q.pop_front();
      end
      m_busy = (cyc <= busy_until);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("rpm",         int'(rpm),         m_rpm);
      check("rpm_valid",   int'(rpm_valid),   int'(m_valid));
      check("rpm_sat",     int'(rpm_sat),     int'(m_sat));
      check("busy",        int'(busy),        int'(m_busy));
      check("missed_tick", int'(missed_tick), int'(m_missed));
    end
  end

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      hall_in = 1'b1;
      repeat (hi) @(negedge clk);
      hall_in = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic wait_valid(input string name, input int exp_rpm, input int exp_sat);
    bit found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gate_tick = 1'b0;
      if (rpm_valid) begin found = 1; break; end
    end
    check({name, "_seen"}, int'(found), 1);
    if (found) begin
      check({name, "_rpm"}, int'(rpm), exp_rpm);
      check({name, "_sat"}, int'(rpm_sat), exp_sat);
    end
    @(negedge clk);
  endtask

  // Tick at the current negedge and require the result exactly RW+2 cycles later
  task automatic tick_check(input string name, input int exp_rpm, input int exp_sat);
    int lat = 0;
    gate_tick = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      gate_tick = 1'b0;
      if (rpm_valid) begin lat = i; break; end
    end
    check({name, "_latency"}, lat, int'(RW) + 2);
    check({name, "_rpm"}, int'(rpm), exp_rpm);
    check({name, "_sat"}, int'(rpm_sat), exp_sat);
    @(negedge clk);
  endtask

  // One 4-cycle pulse with a tick placed t samples after its first high sample
  task automatic edge_tick(input int t);
    for (int k = 0; k < 10; k++) begin
      hall_in   = (k < 4);
      gate_tick = (k == t);
      @(negedge clk);
    end
    hall_in   = 1'b0;
    gate_tick = 1'b0;
  endtask

  initial begin
    int nvalid;
    repeat (3) @(negedge clk);
    check("reset_rpm",       int'(rpm),         0);
    check("reset_rpm_valid", int'(rpm_valid),   0);
    check("reset_rpm_sat",   int'(rpm_sat),     0);
    check("reset_busy",      int'(busy),        0);
    check("reset_missed",    int'(missed_tick), 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    tick_check("zero", 0, 0);

    pulses(20, 20, 20);
    tick_check("basic", 600, 0);

    pulses(1, 1, 10);
    pulses(1, 2, 10);
    pulses(1, 3, 10);
    tick_check("glitch", 0, 0);

    pulses(3, 20, 20);
    edge_tick(6);
    wait_valid("edge_on_tick_old", 90, 0);
    pulses(4, 20, 20);
    tick_check("edge_on_tick_new", 150, 0);

    edge_tick(7);
    wait_valid("edge_before_tick", 30, 0);
    repeat (10) @(negedge clk);
    tick_check("after_edge_before_tick", 0, 0);

    pulses(300, 5, 5);
    tick_check("sat", 7650, 1);
    pulses(5, 20, 20);
    tick_check("post_sat", 150, 0);

    pulses(2, 20, 20);
    gate_tick = 1'b1;
    @(negedge clk); gate_tick = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); gate_tick = 1'b1;
    @(negedge clk); gate_tick = 1'b0;
    check("overrun_missed_early", int'(missed_tick), 1);
    wait_valid("overrun_first", 60, 0);
    check("overrun_missed_sticky", int'(missed_tick), 1);

    repeat (5) @(negedge clk);
    gate_tick = 1'b1;
    @(negedge clk); gate_tick = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_rst", int'(busy), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_rpm",       int'(rpm),         0);
    check("rst_rpm_valid", int'(rpm_valid),   0);
    check("rst_rpm_sat",   int'(rpm_sat),     0);
    check("rst_busy",      int'(busy),        0);
    check("rst_missed",    int'(missed_tick), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rpm_valid) nvalid++;
    end
    check("no_valid_after_rst", nvalid, 0);

    pulses(1, 20, 20);
    tick_check("recover", 30, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule
